clarvi_mem_stage: RTL and testbench
===================================

Name: clarvi_mem_stage

Overview:
RV64 memory-access stage directly downstream of the ALU. It takes the ALU result as an effective address, or as a pass-through writeback value. Loads and stores are performed over a 64-bit Avalon-MM data master, with alignment checking, byte-lane steering and load sign/zero extension. It produces a registered writeback packet for the register-file write stage and stalls the ALU stage through a ready/valid handshake.

Parameters:
ADDR_WIDTH, 32, width of the Avalon byte address; the ALU result is truncated to this width.

Ports:
clock  in  1  single clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  ALU stage presents an instruction
in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready
in_mem_op  in  2  0=NONE (pass-through), 1=LOAD, 2=STORE, 3=reserved (treated as NONE)
in_size  in  2  0=byte, 1=half, 2=word, 3=double
in_unsigned  in  1  load zero-extends when 1
in_alu_result  in  64  effective address, or writeback value for NONE
in_store_data  in  64  rs2 value for stores
in_rd  in  5  destination register
out_valid  out  1  writeback packet valid
out_ready  in  1  writeback stage accepts
out_rd  out  5  destination register; 0 for stores
out_value  out  64  writeback value
out_misaligned  out  1  packet is an alignment exception; no bus access was made
avm_address  out  ADDR_WIDTH  doubleword-aligned byte address
avm_byteenable  out  8  active byte lanes
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  64  lane-steered store data
avm_readdata  in  64  read data
avm_waitrequest  in  1  slave stall
avm_readdatavalid  in  1  read data returned

Behaviour:
- Reset: state IDLE. The outputs out_valid, avm_read, avm_write, out_misaligned and in_ready are 0 during the reset cycle. in_ready is 1 from the first cycle after reset. out_value, out_rd, avm_address, avm_byteenable and avm_writedata are 0.
- FSM states: IDLE, REQ, RDATA, OUT.
- IDLE: in_ready=1. On accept, all inputs are latched.
  - NONE: go to OUT with out_value=in_alu_result. Latency is 1 cycle.
  - Misaligned (address low bits not zero modulo 2^size): go to OUT with out_misaligned=1, out_value=address. No bus access.
  - LOAD/STORE: drive the bus signals from the latched values and go to REQ.
- REQ: hold avm_read or avm_write and all bus fields stable while avm_waitrequest=1.
  - When avm_waitrequest=0, deassert the request in the next cycle.
  - LOAD goes to RDATA.
  - STORE goes to OUT with out_rd=0.
- RDATA: on avm_readdatavalid, set out_value = extend(avm_readdata >> (8*addr[2:0]), size, unsigned), then go to OUT.
  - avm_readdatavalid may arrive as early as the cycle after the request is accepted.
- OUT: out_valid=1 and all out_* fields are stable until out_ready=1, then return to IDLE.
  - in_ready is 0 in OUT. There is no skid buffer, so the best-case throughput is one instruction every 2 cycles.
- Byte lanes:
  - byteenable = ((1<<(1<<size))-1) << addr[2:0].
  - writedata = in_store_data << (8*addr[2:0]). Lanes not enabled carry don't-care data.
  - avm_address = {addr[ADDR_WIDTH-1:3], 3'b000}.
- Extension: size 0/1/2 sign-extend from bit 7/15/31 unless in_unsigned. Size 3 ignores in_unsigned.
- Ignored signals:
  - avm_readdatavalid outside RDATA is ignored; this includes a stray response after reset.
  - in_valid outside IDLE is ignored.
- Reset mid-operation: return to IDLE immediately and drop avm_read/avm_write on the next edge. The outstanding transaction is abandoned.
- Only one outstanding bus transaction at any time.

Decomposition:
- Shared package riscv.svh gains mem_op_t (NONE/LOAD/STORE) and mem_size_t (BYTE/HALF/WORD/DOUBLE) enums. It also gains helper functions byte_enable(size, offset) and load_extend(data, size, unsigned).
- One sub-module is natural: clarvi_load_align. It is purely combinational: readdata, offset, size and unsigned in; the extended 64-bit value out. It is shared with any future load path.

Test Plan:
- NONE, in_alu_result=64'h1234, in_rd=5, out_ready=1 -> out_valid 1 cycle after accept; out_value=64'h1234; out_rd=5; no avm_read/avm_write pulse.
- LOAD byte signed at addr 0x13, readdata=64'h0000_0000_8000_0000, waitrequest held 2 cycles, readdatavalid 3 cycles later:
  - During the request: avm_address=0x10, byteenable=8'h08, avm_read stable for 3 cycles.
  - Result: out_value=64'hFFFF_FFFF_FFFF_FF80.
  - Repeating with in_unsigned=1 gives 64'h80.
- STORE half at addr 0x06, in_store_data=64'hABCD, no wait -> byteenable=8'hC0; writedata[63:48]=16'hABCD; single write cycle; out_rd=0.
- LOAD word at addr 0x02 -> out_misaligned=1, out_value=0x02; avm_read never asserted.
- Write-back stall: out_ready=0 for 4 cycles after a load completes -> out_valid and out_value held; in_ready=0 throughout; a new in_valid is not accepted until the cycle after out_ready=1.
- Reset asserted while in RDATA, then readdatavalid arrives the next cycle -> avm_read=0, out_valid=0, the response is ignored, and in_ready=1 after reset deasserts.

Source files
------------

// File: rtl/clarvi_mem_stage_pkg.sv
// rtl/clarvi_mem_stage_pkg.sv - memory-stage types and byte-lane/extension helpers
package clarvi_mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2,
        MEM_RSVD  = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RDATA = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    function automatic logic [7:0] byte_enable(input mem_size_t size, input logic [2:0] offset);
        logic [7:0] lanes;
        case (size)
            SIZE_BYTE:   lanes = 8'h01;
            SIZE_HALF:   lanes = 8'h03;
            SIZE_WORD:   lanes = 8'h0F;
            default:     lanes = 8'hFF;
        endcase
        return lanes << offset;
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] offset);
        case (size)
            SIZE_BYTE:   return 1'b0;
            SIZE_HALF:   return offset[0];
            SIZE_WORD:   return |offset[1:0];
            default:     return |offset;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] data, input mem_size_t size,
                                                input logic is_unsigned);
        case (size)
            SIZE_BYTE:   return {{56{data[7]  & ~is_unsigned}}, data[7:0]};
            SIZE_HALF:   return {{48{data[15] & ~is_unsigned}}, data[15:0]};
            SIZE_WORD:   return {{32{data[31] & ~is_unsigned}}, data[31:0]};
            default:     return data;
        endcase
    endfunction

endpackage

// File: rtl/clarvi_load_align.sv
// rtl/clarvi_load_align.sv - shifts a 64-bit read beat to lane 0 and extends it to 64 bits
module clarvi_load_align
    import clarvi_mem_stage_pkg::*;
(
    input  logic [63:0] readdata_i,
    input  logic [2:0]  offset_i,
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    output logic [63:0] value_o
);

    logic [63:0] shifted;

    assign shifted = readdata_i >> {offset_i, 3'b000};
    assign value_o = load_extend(shifted, size_i, unsigned_i);

endmodule

// File: rtl/clarvi_mem_stage.sv
// rtl/clarvi_mem_stage.sv - RV64 memory stage: Avalon-MM load/store with registered writeback packet
module clarvi_mem_stage
    import clarvi_mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mem_op,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [63:0]           in_alu_result,
    input  logic [63:0]           in_store_data,
    input  logic [4:0]            in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_rd,
    output logic [63:0]           out_value,
    output logic                  out_misaligned,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [7:0]            avm_byteenable,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [63:0]           avm_writedata,
    input  logic [63:0]           avm_readdata,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid
);

    state_t                state_q, state_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic                  load_q, load_d;
    mem_size_t             size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [2:0]            offset_q, offset_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            be_q, be_d;
    logic [63:0]           wdata_q, wdata_d;
    logic [63:0]           value_q, value_d;
    logic [4:0]            rd_q, rd_d;
    logic                  mis_q, mis_d;

    logic [63:0]           load_value;
    mem_op_t               op_in;
    mem_size_t             size_in;
    logic [2:0]            offset_in;

    assign op_in     = mem_op_t'(in_mem_op);
    assign size_in   = mem_size_t'(in_size);
    assign offset_in = in_alu_result[2:0];

    clarvi_load_align u_load_align (
        .readdata_i (avm_readdata),
        .offset_i   (offset_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .value_o    (load_value)
    );

    always_comb begin
        state_d    = state_q;
        read_d     = read_q;
        write_d    = write_q;
        load_d     = load_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        offset_d   = offset_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        value_d    = value_q;
        rd_d       = rd_q;
        mis_d      = mis_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    size_d     = size_in;
                    unsigned_d = in_unsigned;
                    offset_d   = offset_in;
                    addr_d     = {in_alu_result[ADDR_WIDTH-1:3], 3'b000};
                    be_d       = byte_enable(size_in, offset_in);
                    wdata_d    = in_store_data << {offset_in, 3'b000};
                    load_d     = (op_in == MEM_LOAD);
                    rd_d       = in_rd;
                    mis_d      = 1'b0;
                    // Reserved op encoding behaves exactly like a pass-through.
                    if (op_in != MEM_LOAD && op_in != MEM_STORE) begin
                        value_d = in_alu_result;
                        state_d = ST_OUT;
                    end else if (is_misaligned(size_in, offset_in)) begin
                        mis_d   = 1'b1;
                        value_d = in_alu_result;
                        state_d = ST_OUT;
                    end else begin
                        read_d  = (op_in == MEM_LOAD);
                        write_d = (op_in == MEM_STORE);
                        value_d = '0;
                        if (op_in == MEM_STORE) begin
                            rd_d = '0;
                        end
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = load_q ? ST_RDATA : ST_OUT;
                end
            end
            ST_RDATA: begin
                if (avm_readdatavalid) begin
                    value_d = load_value;
                    state_d = ST_OUT;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            load_q     <= 1'b0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            offset_q   <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            value_q    <= '0;
            rd_q       <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            write_q    <= write_d;
            load_q     <= load_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            offset_q   <= offset_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            value_q    <= value_d;
            rd_q       <= rd_d;
            mis_q      <= mis_d;
        end
    end

    // Handshake and request strobes are forced low while reset is held.
    assign in_ready       = (state_q == ST_IDLE) && !reset;
    assign out_valid      = (state_q == ST_OUT) && !reset;
    assign out_misaligned = mis_q && (state_q == ST_OUT) && !reset;
    assign avm_read       = read_q && !reset;
    assign avm_write      = write_q && !reset;
    assign out_rd         = rd_q;
    assign out_value      = value_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_clarvi_mem_stage.sv
// tb/tb_clarvi_mem_stage.sv - randomized self-checking bench for clarvi_mem_stage
module tb_clarvi_mem_stage;

    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mem_op;
    logic [1:0]    in_size;
    logic          in_unsigned;
    logic [63:0]   in_alu_result;
    logic [63:0]   in_store_data;
    logic [4:0]    in_rd;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    out_rd;
    logic [63:0]   out_value;
    logic          out_misaligned;
    logic [AW-1:0] avm_address;
    logic [7:0]    avm_byteenable;
    logic          avm_read;
    logic          avm_write;
    logic [63:0]   avm_writedata;
    logic [63:0]   avm_readdata;
    logic          avm_waitrequest;
    logic          avm_readdatavalid;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    clarvi_mem_stage #(.ADDR_WIDTH(AW)) dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_mem_op         (in_mem_op),
        .in_size           (in_size),
        .in_unsigned       (in_unsigned),
        .in_alu_result     (in_alu_result),
        .in_store_data     (in_store_data),
        .in_rd             (in_rd),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_rd            (out_rd),
        .out_value         (out_value),
        .out_misaligned    (out_misaligned),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] model_be(input int size, input int off);
        int n;
        n = 1 << size;
        return 8'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] data, input int size, input int off,
                                               input bit uns);
        logic [63:0] sh, mask, v;
        int bits;
        sh = data >> (8 * off);
        if (size == 3) return sh;
        bits = 8 * (1 << size);
        mask = (64'd1 << bits) - 64'd1;
        v = sh & mask;
        if (!uns && sh[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Drives one instruction through the stage with the given bus/writeback timing.
    task automatic run_txn(input int op, input int size, input bit uns, input logic [63:0] alu,
                           input logic [63:0] sd, input logic [4:0] rd, input int wt, input int rdv,
                           input int stall, input logic [63:0] rdata);
        int off, n, reqs;
        bit is_mem, mis;
        logic [63:0] exp_val, exp_wd;
        logic [4:0] exp_rd;
        logic [7:0] exp_be;
        logic [AW-1:0] exp_addr;
        off = int'(alu[2:0]);
        n = 1 << size;
        is_mem = (op == 1) || (op == 2);
        mis = is_mem && ((off % n) != 0);
        exp_be = model_be(size, off);
        exp_wd = sd << (8 * off);
        exp_addr = alu[AW-1:0] & ~AW'(7);
        exp_rd = (op == 2) ? 5'd0 : rd;
        exp_val = alu;
        if (op == 1 && !mis) exp_val = model_load(rdata, size, off, uns);

        out_ready = (stall == 0);
        in_mem_op = 2'(op); in_size = 2'(size); in_unsigned = uns;
        in_alu_result = alu; in_store_data = sd; in_rd = rd; in_valid = 1'b1;
        total++; if (in_ready !== 1'b1) $display("FAIL accept_ready: in_ready=%b want 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;

        if (is_mem && !mis) begin
            reqs = 0;
            for (int c = 0; c <= wt; c++) begin
                avm_waitrequest = (c < wt);
                if (avm_read === (op == 1) && avm_write === (op == 2)) reqs++;
                total++;
                if (avm_address !== exp_addr || avm_byteenable !== exp_be)
                    $display("FAIL bus_fields: addr=%h be=%h want addr=%h be=%h", avm_address, avm_byteenable, exp_addr, exp_be);
                else passed++;
                if (op == 2) begin
                    total++;
                    if ((avm_writedata & lane_mask(exp_be)) !== (exp_wd & lane_mask(exp_be)))
                        $display("FAIL writedata: got %h want %h (lanes %h)", avm_writedata, exp_wd, exp_be);
                    else passed++;
                end
                step();
            end
            avm_waitrequest = 1'b0;
            total++; if (reqs !== wt + 1) $display("FAIL req_cycles: got %0d want %0d", reqs, wt + 1); else passed++;
            total++;
            if (avm_read !== 1'b0 || avm_write !== 1'b0)
                $display("FAIL req_drop: read=%b write=%b want 0 0", avm_read, avm_write);
            else passed++;
            if (op == 1) begin
                for (int i = 0; i < rdv; i++) begin
                    avm_readdata = {$urandom, $urandom};
                    step();
                end
                avm_readdata = rdata; avm_readdatavalid = 1'b1;
                step();
                avm_readdatavalid = 1'b0;
            end
        end else begin
            total++;
            if (avm_read !== 1'b0 || avm_write !== 1'b0)
                $display("FAIL no_bus: read=%b write=%b want 0 0", avm_read, avm_write);
            else passed++;
        end

        for (int s = 0; s <= stall; s++) begin
            out_ready = (s == stall);
            in_valid = (s != stall);
            in_mem_op = 2'd0; in_alu_result = ~alu; in_rd = ~rd;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_misaligned !== mis)
                $display("FAIL out_ctrl: valid=%b ready=%b mis=%b want 1 0 %b", out_valid, in_ready, out_misaligned, mis);
            else passed++;
            if (!(is_mem && !mis && op == 2)) begin
                total++; if (out_value !== exp_val) $display("FAIL out_value: got %h want %h", out_value, exp_val); else passed++;
            end
            if (!mis) begin
                total++; if (out_rd !== exp_rd) $display("FAIL out_rd: got %0d want %0d", out_rd, exp_rd); else passed++;
            end
            step();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL out_done: valid=%b ready=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_mem_op = '0; in_size = '0;
        in_unsigned = 1'b0; in_alu_result = '0; in_store_data = '0; in_rd = '0;
        avm_readdata = 64'hDEAD_BEEF_0000_1111; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || avm_read !== 1'b0 || avm_write !== 1'b0 || out_misaligned !== 1'b0)
            $display("FAIL reset_ctrl: valid=%b ready=%b rd=%b wr=%b mis=%b want all 0",
                     out_valid, in_ready, avm_read, avm_write, out_misaligned);
        else passed++;
        total++;
        if (out_value !== 64'd0 || out_rd !== 5'd0 || avm_address !== '0 || avm_byteenable !== 8'd0 || avm_writedata !== 64'd0)
            $display("FAIL reset_data: value=%h rd=%0d addr=%h be=%h wd=%h want 0",
                     out_value, out_rd, avm_address, avm_byteenable, avm_writedata);
        else passed++;
        reset = 1'b0;
        step();
        avm_readdatavalid = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: ready=%b valid=%b want 1 0", in_ready, out_valid);
        else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL stray_rdv: out_valid=%b want 0", out_valid); else passed++;
    endtask

    task automatic test_none();
        run_txn(0, 0, 1'b0, 64'h1234, 64'h0, 5'd5, 0, 0, 0, 64'h0);
        run_txn(3, 2, 1'b1, 64'hFEDC_BA98_7654_3211, 64'h0, 5'd17, 0, 0, 0, 64'h0);
    endtask

    task automatic test_load();
        run_txn(1, 0, 1'b0, 64'h13, 64'h0, 5'd9, 2, 2, 0, 64'h0000_0000_8000_0000);
        run_txn(1, 0, 1'b1, 64'h13, 64'h0, 5'd9, 2, 2, 0, 64'h0000_0000_8000_0000);
        run_txn(1, 3, 1'b1, 64'h8000_0000_0000_0040, 64'h0, 5'd3, 0, 0, 0, 64'h8765_4321_0FED_CBA9);
        run_txn(1, 2, 1'b0, 64'h24, 64'h0, 5'd31, 1, 0, 0, 64'h8000_0001_0000_0000);
    endtask

    task automatic test_store();
        run_txn(2, 1, 1'b0, 64'h06, 64'hABCD, 5'd12, 0, 0, 0, 64'h0);
        run_txn(2, 3, 1'b0, 64'h1_0000_0108, 64'h0123_4567_89AB_CDEF, 5'd1, 3, 0, 1, 64'h0);
    endtask

    task automatic test_misaligned();
        run_txn(1, 2, 1'b0, 64'h02, 64'h0, 5'd7, 0, 0, 0, 64'h0);
        run_txn(2, 3, 1'b0, 64'h0C, 64'hFFFF, 5'd8, 0, 0, 1, 64'h0);
        run_txn(1, 1, 1'b1, 64'h7F, 64'h0, 5'd4, 0, 0, 0, 64'h0);
    endtask

    task automatic test_stall();
        run_txn(1, 1, 1'b0, 64'h2A, 64'h0, 5'd22, 0, 0, 4, 64'h0000_F00D_8001_0000);
        run_txn(0, 0, 1'b0, 64'h5555, 64'h0, 5'd2, 0, 0, 4, 64'h0);
    endtask

    task automatic test_reset_mid();
        in_mem_op = 2'd1; in_size = 2'd2; in_unsigned = 1'b0; in_alu_result = 64'h40; in_rd = 5'd6;
        avm_waitrequest = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        total++;
        if (avm_read !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL mid_reset: read=%b valid=%b ready=%b want 0 0 0", avm_read, out_valid, in_ready);
        else passed++;
        step();
        reset = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 64'h1111_2222_3333_4444;
        #1;
        total++;
        if (in_ready !== 1'b1 || avm_read !== 1'b0)
            $display("FAIL mid_release: ready=%b read=%b want 1 0", in_ready, avm_read);
        else passed++;
        step();
        avm_readdatavalid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_ignored: valid=%b ready=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_random();
        int op, size, off;
        logic [63:0] alu;
        for (int t = 0; t < 60; t++) begin
            op = int'($urandom_range(0, 3));
            size = int'($urandom_range(0, 3));
            alu = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) alu = alu & ~((64'd1 << size) - 64'd1);
            off = int'(alu[2:0]);
            if ((op == 1 || op == 2) && (off % (1 << size)) != 0) alu[63:32] = '0;
            run_txn(op, size, 1'($urandom), alu, {$urandom, $urandom}, 5'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    {$urandom, $urandom});
        end
    endtask

    initial begin
        test_reset();
        test_none();
        test_load();
        test_store();
        test_misaligned();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
